// File: rtl/wave_pkg.sv
// Shared geometry and capture-state encodings for the waveform capture/display pair.
package wave_pkg;

    localparam int DISP_W = 8;
    localparam int ADDR_W = 8;

    typedef enum logic [1:0] {
        WC_ARMED  = 2'd0,
        WC_ACTIVE = 2'd1,
        WC_WAIT   = 2'd2
    } wc_state_e;

endpackage

// File: rtl/zero_cross_detect.sv
// Remembers the last accepted sample and flags a negative-to-non-negative transition.
module zero_cross_detect #(
    parameter int SAMPLE_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       new_sample_ready,
    input  logic signed [SAMPLE_W-1:0] new_sample_in,
    output logic                       pos_crossing
);

    logic signed [SAMPLE_W-1:0] r_prev_sample;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_sample <= '0;
        end else if (new_sample_ready) begin
            r_prev_sample <= new_sample_in;
        end
    end

    // Sign bits alone decide the crossing: previous < 0 and current >= 0.
    assign pos_crossing = new_sample_ready
                        && r_prev_sample[SAMPLE_W-1]
                        && !new_sample_in[SAMPLE_W-1];

endmodule

// File: rtl/wave_capture.sv
// Arms on a positive zero crossing, fills the idle RAM half with one capture,
// then swaps halves once the display reports idle.
module wave_capture
    import wave_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int DISP_W   = wave_pkg::DISP_W,
    parameter int ADDR_W   = wave_pkg::ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                new_sample_ready,
    input  logic [SAMPLE_W-1:0] new_sample_in,
    input  logic                wave_display_idle,
    output logic [ADDR_W:0]     write_address,
    output logic                write_enable,
    output logic [DISP_W-1:0]   write_sample,
    output logic                read_index,
    output wc_state_e           debug_state
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    wc_state_e           r_state;
    wc_state_e           w_next_state;
    logic [ADDR_W-1:0]   r_count;
    logic [ADDR_W-1:0]   w_next_count;
    logic [ADDR_W-1:0]   w_write_idx;
    logic                w_write;
    logic                w_next_read_index;
    logic                w_pos_crossing;

    logic                r_write_enable;
    logic [ADDR_W:0]     r_write_address;
    logic [DISP_W-1:0]   r_write_sample;
    logic                r_read_index;

    zero_cross_detect #(
        .SAMPLE_W (SAMPLE_W)
    ) u_zero_cross_detect (
        .clk              (clk),
        .reset            (reset),
        .new_sample_ready (new_sample_ready),
        .new_sample_in    (new_sample_in),
        .pos_crossing     (w_pos_crossing)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= WC_ARMED;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
        end
    end

    always_comb begin
        w_next_state      = r_state;
        w_next_count      = r_count;
        w_write           = 1'b0;
        w_write_idx       = r_count;
        w_next_read_index = r_read_index;
        case (r_state)
            WC_ARMED: begin
                if (w_pos_crossing) begin
                    w_write      = 1'b1;
                    w_write_idx  = '0;
                    w_next_count = {{(ADDR_W-1){1'b0}}, 1'b1};
                    w_next_state = WC_ACTIVE;
                end
            end
            WC_ACTIVE: begin
                if (new_sample_ready) begin
                    w_write = 1'b1;
                    if (r_count == LAST_IDX) begin
                        w_next_count = '0;
                        w_next_state = WC_WAIT;
                    end else begin
                        w_next_count = r_count + 1'b1;
                    end
                end
            end
            WC_WAIT: begin
                // Strobes here only refresh the crossing history.
                if (wave_display_idle) begin
                    w_next_read_index = ~r_read_index;
                    w_next_state      = WC_ARMED;
                end
            end
            default: begin
                w_next_state = WC_ARMED;
            end
        endcase
    end

    // Address/data hold their last value between writes; only the strobe pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_write_enable  <= 1'b0;
            r_write_address <= '0;
            r_write_sample  <= '0;
            r_read_index    <= 1'b0;
        end else begin
            r_write_enable <= w_write;
            r_read_index   <= w_next_read_index;
            if (w_write) begin
                r_write_address <= {~r_read_index, w_write_idx};
                r_write_sample  <= {~new_sample_in[SAMPLE_W-1],
                                    new_sample_in[SAMPLE_W-2 -: DISP_W-1]};
            end
        end
    end

    assign write_enable  = r_write_enable;
    assign write_address = r_write_address;
    assign write_sample  = r_write_sample;
    assign read_index    = r_read_index;
    assign debug_state   = r_state;

endmodule

// File: tb/tb_wave_capture.sv
// Bench for wave_capture: vector table, directed capture/swap/reset sequences, random stream vs model.
module tb_wave_capture;
  import wave_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_sample_ready;
  logic [15:0] new_sample_in;
  logic        wave_display_idle;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;
  wc_state_e   debug_state;

  int checks = 0;
  int errors = 0;

  // model: 0 = waiting for crossing, 1 = capturing, 2 = waiting for display idle
  int m_mode;
  int m_prev;
  int m_idx;
  int m_ri;
  logic [8:0] exp_q[$];

  typedef struct {
    logic        rdy;
    logic [15:0] s;
    logic        idle;
    logic        exp_we;
    logic [8:0]  exp_addr;
    logic [7:0]  exp_data;
  } vec_t;

  wave_capture dut (
    .clk               (clk),
    .reset             (reset),
    .new_sample_ready  (new_sample_ready),
    .new_sample_in     (new_sample_in),
    .wave_display_idle (wave_display_idle),
    .write_address     (write_address),
    .write_enable      (write_enable),
    .write_sample      (write_sample),
    .read_index        (read_index),
    .debug_state       (debug_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_prev = 0;
    m_idx  = 0;
    m_ri   = 0;
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input logic rdy, input logic [15:0] s, input logic idle);
    int   sv;
    int   exp_we;
    int   exp_addr;
    int   exp_data;
    int   exp_state;
    new_sample_ready  = rdy;
    new_sample_in     = s;
    wave_display_idle = idle;
    sv       = int'($signed(s));
    exp_we   = 0;
    exp_addr = 0;
    exp_data = ((int'(s) >> 8) & 255) ^ 128;
    if (m_mode == 2) begin
      if (idle) begin
        m_ri   = 1 - m_ri;
        m_mode = 0;
      end
    end else if (rdy) begin
      if (m_mode == 0 && m_prev < 0 && sv >= 0) begin
        exp_we   = 1;
        exp_addr = (1 - m_ri) * 256;
        m_idx    = 1;
        m_mode   = 1;
      end else if (m_mode == 1) begin
        exp_we   = 1;
        exp_addr = (1 - m_ri) * 256 + m_idx;
        m_idx    = m_idx + 1;
        if (m_idx == 256) begin
          m_idx  = 0;
          m_mode = 2;
        end
      end
    end
    if (rdy) m_prev = sv;
    exp_state = (m_mode == 0) ? int'(WC_ARMED) : (m_mode == 1) ? int'(WC_ACTIVE) : int'(WC_WAIT);
    @(posedge clk);
    #1;
    chk("model_we", int'(write_enable), exp_we);
    if (exp_we != 0 && write_enable) begin
      chk("model_addr", int'(write_address), exp_addr);
      chk("model_data", int'(write_sample), exp_data);
      exp_q.push_back(write_address);
    end
    chk("model_read_index", int'(read_index), m_ri);
    chk("model_state", int'(debug_state), exp_state);
    new_sample_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    new_sample_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk("rst_we", int'(write_enable), 0);
    chk("rst_addr", int'(write_address), 0);
    chk("rst_data", int'(write_sample), 0);
    chk("rst_read_index", int'(read_index), 0);
    chk("rst_state", int'(debug_state), int'(WC_ARMED));
  endtask

  vec_t vecs[8];

  initial begin
    int   run_len;
    int   prev_addr;
    logic [15:0] rs;

    reset             = 1'b1;
    new_sample_ready  = 1'b0;
    new_sample_in     = '0;
    wave_display_idle = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    vecs[0] = '{1'b1, 16'd100,  1'b0, 1'b0, 9'h000, 8'h00};
    vecs[1] = '{1'b1, 16'd200,  1'b0, 1'b0, 9'h000, 8'h00};
    vecs[2] = '{1'b1, 16'hFFFB, 1'b0, 1'b0, 9'h000, 8'h00};
    vecs[3] = '{1'b1, 16'd3,    1'b0, 1'b1, 9'h100, 8'h80};
    vecs[4] = '{1'b0, 16'h4444, 1'b0, 1'b0, 9'h000, 8'h00};
    vecs[5] = '{1'b1, 16'h1234, 1'b0, 1'b1, 9'h101, 8'h92};
    vecs[6] = '{1'b1, 16'hFFFF, 1'b0, 1'b1, 9'h102, 8'h7F};
    vecs[7] = '{1'b1, 16'h8000, 1'b1, 1'b1, 9'h103, 8'h00};
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].rdy, vecs[i].s, vecs[i].idle);
      chk("tbl_we", int'(write_enable), int'(vecs[i].exp_we));
      if (vecs[i].exp_we) begin
        chk("tbl_addr", int'(write_address), int'(vecs[i].exp_addr));
        chk("tbl_data", int'(write_sample), int'(vecs[i].exp_data));
      end
      if (i == 3) chk("tbl_state_active", int'(debug_state), int'(WC_ACTIVE));
    end

    // Finish the capture at index 255 with full-scale positive samples.
    for (int i = 4; i < 256; i++) begin
      step(1'b1, 16'h7F00, 1'b0);
      chk("fill_data", int'(write_sample), 8'hFF);
    end
    chk("fill_last_addr", int'(write_address), 9'h1FF);
    chk("fill_wait", int'(debug_state), int'(WC_WAIT));
    step(1'b1, 16'h7F00, 1'b0);
    chk("extra_not_written", int'(write_enable), 0);

    for (int i = 0; i < 50; i++) step(i[0], 16'h8123, 1'b0);
    chk("hold_read_index", int'(read_index), 0);
    // Swap coincident with a negative strobe; the next positive sample arms.
    step(1'b1, 16'hFFF9, 1'b1);
    chk("swap_read_index", int'(read_index), 1);
    chk("swap_no_write", int'(write_enable), 0);
    step(1'b1, 16'd5, 1'b0);
    chk("rearm_addr", int'(write_address), 9'h000);
    chk("rearm_we", int'(write_enable), 1);
    for (int i = 1; i < 256; i++) step(1'b1, 16'($urandom_range(0, 65535)), 1'b0);
    chk("second_last_addr", int'(write_address), 9'h0FF);

    // Reset 100 samples into a capture.
    step(1'b1, 16'h7000, 1'b1);
    step(1'b1, 16'hF000, 1'b0);
    step(1'b1, 16'h0100, 1'b0);
    for (int i = 1; i < 100; i++) step(1'b1, 16'($urandom_range(0, 65535)), 1'b0);
    do_reset();
    step(1'b1, 16'h8000, 1'b0);
    step(1'b1, 16'h0000, 1'b0);
    chk("post_reset_addr", int'(write_address), 9'h100);

    // Random stream against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rs = 16'($urandom_range(0, 65535));
      step($urandom_range(0, 3) != 0, rs, $urandom_range(0, 15) == 0);
    end

    // Back-to-back capture: 256 consecutive writes, strictly incrementing addresses.
    do_reset();
    step(1'b1, 16'hC000, 1'b0);
    run_len   = 0;
    prev_addr = -1;
    for (int i = 0; i < 260; i++) begin
      step(1'b1, (i == 0) ? 16'h0000 : 16'($urandom_range(0, 65535)), 1'b0);
      if (write_enable) begin
        if (prev_addr >= 0) chk("b2b_incr", int'(write_address), prev_addr + 1);
        prev_addr = int'(write_address);
        run_len++;
      end
    end
    chk("b2b_run_len", run_len, 256);
    chk("b2b_writes_seen", (exp_q.size() > 256) ? 1 : 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
